// File: rtl/moore_seq_detector_param_pkg.sv
// Shared types and default sizing for the programmable sequence detector.
package moore_seq_detector_param_pkg;

    typedef enum logic {
        MODE_NONOVERLAP = 1'b0,
        MODE_OVERLAP    = 1'b1
    } mode_e;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/moore_seq_detector_param_if.sv
// Serial data + configuration bus of the sequence detector.
interface moore_seq_detector_param_if
    import moore_seq_detector_param_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               x;
    logic               x_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               z;
    logic [CNT_W-1:0]   match_cnt;

    modport master (
        output x, x_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        input  z, match_cnt
    );

    modport slave (
        input  x, x_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        output z, match_cnt
    );

endinterface

// File: rtl/moore_seq_detector_param_sat_counter.sv
// Up counter with synchronous clear that sticks at MAX instead of wrapping.
module moore_seq_detector_param_sat_counter #(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != MAX))
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/moore_seq_detector_param.sv
// Runtime-programmable serial pattern detector with registered (Moore) match flag
// and a saturating match counter.
module moore_seq_detector_param
    import moore_seq_detector_param_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                        clk,
    input  logic                        rst,
    moore_seq_detector_param_if.slave   bus
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] n);
        logic [MAX_LEN-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LEN; i++)
            if (i < int'(n)) m[i] = 1'b1;
        return m;
    endfunction

    logic [MAX_LEN-1:0] pattern;
    logic [MAX_LEN-1:0] history;
    logic [MAX_LEN-1:0] hist_next;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   len_clamped;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_next;
    mode_e              mode;
    logic               accept;
    logic               match;
    logic               fill_clr;
    logic               z_q;

    // A config load drops any bit presented in the same cycle.
    always_comb begin
        accept      = bus.x_valid & ~bus.cfg_load;
        hist_next   = MAX_LEN'({history, bus.x});
        fill_next   = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
        len_clamped = (bus.cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.cfg_len;
        match       = accept && (len != '0) && (fill_next >= len) &&
                      (((hist_next ^ pattern) & len_mask(len)) == '0);
        fill_clr    = bus.cfg_load | (match & (mode == MODE_NONOVERLAP));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern <= '0;
            len     <= '0;
            mode    <= MODE_OVERLAP;
        end else if (bus.cfg_load) begin
            pattern <= bus.cfg_pattern;
            len     <= len_clamped;
            mode    <= mode_e'(bus.cfg_overlap);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            history <= '0;
        else if (bus.cfg_load)
            history <= '0;
        else if (accept)
            history <= hist_next;
    end

    // match is already low on load and idle cycles, so z is a one-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            z_q <= 1'b0;
        else
            z_q <= match;
    end

    assign bus.z = z_q;

    // Clearing fill after a non-overlapping match makes the stale history invisible.
    moore_seq_detector_param_sat_counter #(
        .W   (LEN_W),
        .MAX (LEN_W'(MAX_LEN))
    ) u_fill (
        .clk (clk),
        .rst (rst),
        .clr (fill_clr),
        .inc (accept),
        .cnt (fill)
    );

    moore_seq_detector_param_sat_counter #(
        .W   (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.cfg_load),
        .inc (match),
        .cnt (bus.match_cnt)
    );

endmodule

// File: tb/tb_moore_seq_detector_param.sv
// Directed and randomized checks of the sequence detector against a queue-based model.
module tb_moore_seq_detector_param;

    localparam int MAX_LEN = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       x, x_valid, cfg_load, cfg_overlap;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;

    int errors = 0;
    int checks = 0;

    moore_seq_detector_param_if #(.MAX_LEN(MAX_LEN), .CNT_W(8)) bus8 ();
    moore_seq_detector_param_if #(.MAX_LEN(MAX_LEN), .CNT_W(2)) bus2 ();

    assign bus8.x = x;            assign bus2.x = x;
    assign bus8.x_valid = x_valid; assign bus2.x_valid = x_valid;
    assign bus8.cfg_load = cfg_load; assign bus2.cfg_load = cfg_load;
    assign bus8.cfg_pattern = cfg_pattern; assign bus2.cfg_pattern = cfg_pattern;
    assign bus8.cfg_len = cfg_len; assign bus2.cfg_len = cfg_len;
    assign bus8.cfg_overlap = cfg_overlap; assign bus2.cfg_overlap = cfg_overlap;

    moore_seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut8 (
        .clk (clk), .rst (rst), .bus (bus8.slave));
    moore_seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2.slave));

    always #5 clk = ~clk;

    // Model: the accepted bits since the last clear, newest at the back.
    bit         hq[$];
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    int         m_cnt;
    bit         e_z;
    logic [31:0] zlog;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hq.delete();
        m_pat = '0; m_len = 0; m_ovl = 1'b1; m_cnt = 0; e_z = 1'b0;
    endtask

    function automatic bit model_match();
        if (m_len == 0 || hq.size() < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++)
            if (hq[hq.size() - 1 - i] != m_pat[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else if (cfg_load) begin
            m_pat = cfg_pattern;
            m_len = (int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
            m_ovl = cfg_overlap;
            hq.delete();
            m_cnt = 0;
            e_z = 1'b0;
        end else if (x_valid) begin
            hq.push_back(x);
            if (hq.size() > MAX_LEN) void'(hq.pop_front());
            e_z = model_match();
            if (e_z) begin
                m_cnt++;
                if (!m_ovl) hq.delete();
            end
        end else begin
            e_z = 1'b0;
        end
    endtask

    task automatic compare();
        check("z_cnt8", 32'(bus8.z), 32'(e_z));
        check("z_cnt2", 32'(bus2.z), 32'(e_z));
        check("cnt8", 32'(bus8.match_cnt), (m_cnt > 255) ? 255 : m_cnt);
        check("cnt2", 32'(bus2.match_cnt), (m_cnt > 3) ? 3 : m_cnt);
    endtask

    // Inputs change at negedge; the model samples at posedge; outputs checked at negedge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        zlog = {zlog[30:0], bus8.z};
    endtask

    task automatic send(input bit b);
        x = b; x_valid = 1'b1; cfg_load = 1'b0;
        tick();
    endtask

    task automatic idle();
        x = 1'($urandom); x_valid = 1'b0; cfg_load = 1'b0;
        tick();
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input bit o);
        cfg_pattern = p; cfg_len = l; cfg_overlap = o;
        cfg_load = 1'b1; x_valid = 1'b1; x = 1'b1;
        tick();
        cfg_load = 1'b0; x_valid = 1'b0;
        zlog = '0;
    endtask

    task automatic send_bits(input logic [7:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) send(bits[i]);
    endtask

    initial begin
        rst = 1'b1; x = 1'b0; x_valid = 1'b0; cfg_load = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b1;
        zlog = '0;
        model_reset();
        @(negedge clk);
        tick(); tick();
        check("reset_z", 32'(bus8.z), 0);
        check("reset_cnt", 32'(bus8.match_cnt), 0);
        rst = 1'b0;

        // Idle detector: no match without a load.
        zlog = '0;
        for (int i = 0; i < 20; i++) send(1'($urandom));
        check("idle_zlog", zlog, 0);

        // Overlapping 1011 on 1011011.
        load(8'b1011, 4'd4, 1'b1);
        send_bits(8'b1011011, 7);
        check("ovl_zlog", zlog, 32'b0001001);
        check("ovl_cnt", 32'(bus8.match_cnt), 2);

        // Asynchronous reset right after a match pulse.
        rst = 1'b1;
        #1;
        check("async_z", 32'(bus8.z), 0);
        check("async_cnt", 32'(bus8.match_cnt), 0);
        model_reset();
        x = 1'b1; x_valid = 1'b1;
        tick();
        rst = 1'b0;
        zlog = '0;
        send_bits(8'b1011, 4);
        check("post_rst_zlog", zlog, 0);

        // Non-overlapping.
        load(8'b1011, 4'd4, 1'b0);
        send_bits(8'b1011011, 7);
        check("novl_zlog", zlog, 32'b0001000);
        check("novl_cnt", 32'(bus8.match_cnt), 1);

        // Gapped valid.
        load(8'b1011, 4'd4, 1'b1);
        send(1'b1); idle(); idle(); idle();
        send(1'b0); idle(); idle(); idle();
        send(1'b1); idle(); idle(); idle();
        send(1'b1); idle(); idle(); idle();
        check("gap_zlog", zlog, 32'b0000_0000_0000_1000);
        check("gap_cnt", 32'(bus8.match_cnt), 1);

        // Length 1 in both modes.
        for (int o = 0; o < 2; o++) begin
            load(8'h01, 4'd1, 1'(o));
            send_bits(8'b1101, 4);
            check("len1_zlog", zlog, 32'b1101);
        end

        // Full length and clamped length.
        load(8'hA5, 4'd8, 1'b1);
        send_bits(8'hA5, 8);
        check("len8_zlog", zlog, 32'b00000001);
        load(8'hA5, 4'd12, 1'b1);
        send_bits(8'hA5, 8);
        check("clamp_zlog", zlog, 32'b00000001);

        // Reload three bits into a match drops the partial.
        load(8'b1011, 4'd4, 1'b1);
        send_bits(8'b101, 3);
        load(8'b1011, 4'd4, 1'b1);
        send(1'b1);
        check("reload_zlog", zlog, 0);
        check("reload_cnt", 32'(bus8.match_cnt), 0);

        // Saturation of the 2-bit counter.
        load(8'h01, 4'd1, 1'b1);
        send_bits(8'b11111, 5);
        check("sat_cnt2", 32'(bus2.match_cnt), 3);
        check("sat_cnt8", 32'(bus8.match_cnt), 5);

        // Randomized traffic with occasional reloads and resets.
        load(8'($urandom), 4'($urandom_range(1, 4)), 1'($urandom));
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 39) == 0) begin
                cfg_load = 1'b1;
                cfg_pattern = 8'($urandom);
                cfg_len = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                      : 4'($urandom_range(1, 4));
                cfg_overlap = 1'($urandom);
            end else begin
                cfg_load = 1'b0;
            end
            x = 1'($urandom);
            x_valid = ($urandom_range(0, 9) < 7);
            tick();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
